// File: rtl/id_ex_stage_pkg.sv
// Shared types and constants for the ID/EX pipeline register slice.
// The E-stage control bundle travels as one packed struct so flush and reset clear it in a single assignment.
package id_ex_stage_pkg;

    localparam int DATA_WIDTH_DEF     = 32;
    localparam int REG_ADDR_WIDTH_DEF = 5;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_SLT = 3'b101
    } alu_op_e;

    typedef struct packed {
        alu_op_e alu_control;
        logic    alu_src;
        logic    reg_write;
        logic    valid;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '{alu_control: ALU_ADD, alu_src: 1'b0, reg_write: 1'b0, valid: 1'b0};

endpackage

// File: rtl/id_ex_stage_forward_mux.sv
// One operand's MEM/WB bypass select; exists only when FORWARDING_EN is defined.
// Combinational, zero latency; MEM wins over WB and x0 is never bypassed.
`ifdef FORWARDING_EN
module forward_mux #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic [REG_ADDR_WIDTH-1:0] rs,
    input  logic [DATA_WIDTH-1:0]     reg_val,
    input  logic                      reg_write_m,
    input  logic [REG_ADDR_WIDTH-1:0] rd_m,
    input  logic [DATA_WIDTH-1:0]     alu_result_m,
    input  logic                      reg_write_w,
    input  logic [REG_ADDR_WIDTH-1:0] rd_w,
    input  logic [DATA_WIDTH-1:0]     result_w,
    output logic [DATA_WIDTH-1:0]     fwd
);

    always_comb begin
        fwd = reg_val;
        if (reg_write_m && (rd_m != '0) && (rd_m == rs)) begin
            fwd = alu_result_m;
        end else if (reg_write_w && (rd_w != '0) && (rd_w == rs)) begin
            fwd = result_w;
        end
    end

endmodule
`endif

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register feeding the ALU; one-edge D->E latency, operands bypassed combinationally.
// StallE holds E state (operands refresh from the bypass), FlushE loads a bubble; optional feature macro FORWARDING_EN.
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
    parameter int REG_ADDR_WIDTH = REG_ADDR_WIDTH_DEF
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      StallE,
    input  logic                      FlushE,
    input  logic                      ValidD,
    input  logic [DATA_WIDTH-1:0]     RD1D,
    input  logic [DATA_WIDTH-1:0]     RD2D,
    input  logic [DATA_WIDTH-1:0]     ImmExtD,
    input  logic [DATA_WIDTH-1:0]     PCD,
    input  logic [REG_ADDR_WIDTH-1:0] Rs1D,
    input  logic [REG_ADDR_WIDTH-1:0] Rs2D,
    input  logic [REG_ADDR_WIDTH-1:0] RdD,
    input  logic [2:0]                ALUControlD,
    input  logic                      ALUSrcD,
    input  logic                      RegWriteD,
    input  logic [DATA_WIDTH-1:0]     ALUResultM,
    input  logic [DATA_WIDTH-1:0]     ResultW,
    input  logic [REG_ADDR_WIDTH-1:0] RdM,
    input  logic [REG_ADDR_WIDTH-1:0] RdW,
    input  logic                      RegWriteM,
    input  logic                      RegWriteW,
    output logic [DATA_WIDTH-1:0]     SrcAE,
    output logic [DATA_WIDTH-1:0]     SrcBE,
    output logic [2:0]                ALUControlE,
    output logic [DATA_WIDTH-1:0]     WriteDataE,
    output logic [DATA_WIDTH-1:0]     PCE,
    output logic [REG_ADDR_WIDTH-1:0] RdE,
    output logic                      RegWriteE,
    output logic                      ValidE
);

    logic [DATA_WIDTH-1:0]     rd1_e, rd2_e, imm_e, pc_e;
    logic [REG_ADDR_WIDTH-1:0] rs1_e, rs2_e, rd_e;
    ctrl_t                     ctrl_e;
    logic [DATA_WIDTH-1:0]     fwd_a, fwd_b;

`ifdef FORWARDING_EN
    forward_mux #(.DATA_WIDTH(DATA_WIDTH), .REG_ADDR_WIDTH(REG_ADDR_WIDTH)) u_fwd_a (
        .rs(rs1_e), .reg_val(rd1_e),
        .reg_write_m(RegWriteM), .rd_m(RdM), .alu_result_m(ALUResultM),
        .reg_write_w(RegWriteW), .rd_w(RdW), .result_w(ResultW),
        .fwd(fwd_a)
    );
    forward_mux #(.DATA_WIDTH(DATA_WIDTH), .REG_ADDR_WIDTH(REG_ADDR_WIDTH)) u_fwd_b (
        .rs(rs2_e), .reg_val(rd2_e),
        .reg_write_m(RegWriteM), .rd_m(RdM), .alu_result_m(ALUResultM),
        .reg_write_w(RegWriteW), .rd_w(RdW), .result_w(ResultW),
        .fwd(fwd_b)
    );
`else
    // Hazard unit stalls instead of bypassing, so the later-stage taps go nowhere.
    logic unused_fwd;
    assign unused_fwd = ^{ALUResultM, ResultW, RdM, RdW, RegWriteM, RegWriteW, rs1_e, rs2_e};
    assign fwd_a = rd1_e;
    assign fwd_b = rd2_e;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd1_e  <= '0;
            rd2_e  <= '0;
            imm_e  <= '0;
            pc_e   <= '0;
            rs1_e  <= '0;
            rs2_e  <= '0;
            rd_e   <= '0;
            ctrl_e <= CTRL_BUBBLE;
        end else if (FlushE) begin
            rd1_e  <= '0;
            rd2_e  <= '0;
            imm_e  <= '0;
            pc_e   <= '0;
            rs1_e  <= '0;
            rs2_e  <= '0;
            rd_e   <= '0;
            ctrl_e <= CTRL_BUBBLE;
        end else if (StallE) begin
            // Capture bypassed operands so they survive the producer leaving WB mid-stall.
            rd1_e <= fwd_a;
            rd2_e <= fwd_b;
        end else begin
            rd1_e                <= RD1D;
            rd2_e                <= RD2D;
            imm_e                <= ImmExtD;
            pc_e                 <= PCD;
            rs1_e                <= Rs1D;
            rs2_e                <= Rs2D;
            rd_e                 <= RdD;
            ctrl_e.alu_control   <= alu_op_e'(ALUControlD);
            ctrl_e.alu_src       <= ALUSrcD;
            ctrl_e.reg_write     <= RegWriteD & ValidD;
            ctrl_e.valid         <= ValidD;
        end
    end

    assign SrcAE       = fwd_a;
    assign SrcBE       = ctrl_e.alu_src ? imm_e : fwd_b;
    assign WriteDataE  = fwd_b;
    assign ALUControlE = ctrl_e.alu_control;
    assign PCE         = pc_e;
    assign RdE         = rd_e;
    assign RegWriteE   = ctrl_e.reg_write;
    assign ValidE      = ctrl_e.valid;

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

Pipeline register between the decode stage and the ALU in the pipelined RV32I core. Captures decoded operands and control each cycle, applies stall/flush, and drives the ALU operand inputs (SrcA, SrcB, ALUControl) through EX/MEM and MEM/WB forwarding muxes. Everything the ALU consumes passes through this block.

## Interface
- DATA_WIDTH, 32, operand/PC width
- REG_ADDR_WIDTH, 5, register index width
- clk  in  1  clock; all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- StallE  in  1  hold all E-stage state
- FlushE  in  1  load a bubble next edge
- ValidD  in  1  decode slot holds a real instruction
- RD1D, RD2D, ImmExtD, PCD  in  DATA_WIDTH  register-file reads, extended immediate, PC
- Rs1D, Rs2D, RdD  in  REG_ADDR_WIDTH  source/destination indices
- ALUControlD  in  3  ALU op (000 add, 001 sub, 010 and, 011 or, 101 slt)
- ALUSrcD  in  1  1 = SrcB takes immediate
- RegWriteD  in  1  instruction writes Rd
- ALUResultM, ResultW  in  DATA_WIDTH  forwarding sources from MEM and WB
- RdM, RdW  in  REG_ADDR_WIDTH  destinations in MEM and WB
- RegWriteM, RegWriteW  in  1  write enables in MEM and WB
- SrcAE, SrcBE  out  DATA_WIDTH  ALU operands
- ALUControlE  out  3  registered ALU op
- WriteDataE  out  DATA_WIDTH  forwarded rs2 value for stores
- PCE  out  DATA_WIDTH; RdE  out  REG_ADDR_WIDTH; RegWriteE, ValidE  out  1

## Operation
- Registered state: RD1E, RD2E, ImmExtE, PCE, Rs1E, Rs2E, RdE, ALUControlE, ALUSrcE, RegWriteE, ValidE.
- Priority per edge: reset > FlushE > StallE > load.
- Load: all D inputs captured.
- FlushE (with or without StallE): bubble — ValidE=0, RegWriteE=0, ALUControlE=000, all data/index registers 0.
- StallE without FlushE: control, indices, ImmExtE, PCE hold; RD1E/RD2E reload with current forwarded values (FwdA/FwdB) so an operand survives its producer retiring from WB during the stall.
- Forwarding (per operand, X = Rs1E or Rs2E): if RegWriteM && RdM!=0 && RdM==X → ALUResultM; else if RegWriteW && RdW!=0 && RdW==X → ResultW; else RD1E/RD2E. MEM beats WB when both match.
- SrcAE = FwdA; SrcBE = ALUSrcE ? ImmExtE : FwdB; WriteDataE = FwdB regardless of ALUSrcE.
- x0 is never forwarded; Rs=0 always reads the registered value (0).
- Bubble outputs: SrcAE = SrcBE = 0, ALUControlE = 000, so the ALU produces 0.

## Timing
- D→E latency: one edge; forwarding muxes are combinational from registered state plus M/W inputs, settling within the same cycle.
- Reset (asynchronous assert, synchronous-safe release): every register 0; hence SrcAE, SrcBE, WriteDataE, PCE, RdE = 0, ALUControlE = 000, RegWriteE = ValidE = 0 immediately on rst_n low.
- Reset mid-stall or mid-flush: reset wins; first post-reset edge follows normal priority.
- StallE held N cycles: outputs stable except SrcAE/SrcBE, which track forwarding until the next load.
- ValidD=0 loads as a bubble-equivalent but keeps captured data; RegWriteE forced 0 when ValidD=0.

## Configuration
- FORWARDING_EN defined: forwarding muxes and stall-time operand refresh as above.
- Undefined: FwdA = RD1E, FwdB = RD2E; M/W inputs unused; stall holds RD1E/RD2E unchanged. Hazards are then resolved entirely by stalling in the hazard unit.

## Structure
- Shared package: alu_op_e enum (ADD=000, SUB=001, AND=010, OR=011, SLT=101), DATA_WIDTH/REG_ADDR_WIDTH constants, packed struct for the E-stage control bundle (ALUControl, ALUSrc, RegWrite, Valid).
- Sub-module: forward_mux, instantiated twice (rs1, rs2); compiled only under FORWARDING_EN.

## Test plan
- Reset: rst_n=0 with D inputs nonzero → all outputs 0, ALUControlE=000 without waiting for clk.
- Plain load: RD1D=5, RD2D=7, ALUSrcD=0, ALUControlD=001 → next cycle SrcAE=5, SrcBE=7, ALUControlE=001.
- Forward priority: Rs1E=3, RdM=RdW=3, both RegWrite=1, ALUResultM=0xAA, ResultW=0xBB → SrcAE=0xAA; drop RegWriteM → 0xBB; Rs1E=0 with RdM=0 → SrcAE=0.
- Immediate path: ALUSrcE=1, ImmExtE=0xFFFFFFF0, Rs2E forwarded 0x11 → SrcBE=0xFFFFFFF0, WriteDataE=0x11.
- Stall refresh: Rs1E=4, WB forwards 0x55 while StallE=1, next cycle RdW≠4 → SrcAE stays 0x55; D inputs changed during stall are ignored.
- Flush over stall: FlushE=StallE=1 with RegWriteE=1 → next edge ValidE=0, RegWriteE=0, SrcAE=SrcBE=0.
